imm_extend_pipe: RTL

//  Parametrised, pipelined immediate extender. Widens an IN_W-bit immediate to OUT_W

---
 rtl/imm_extend_pipe.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - pipelined IN_W->OUT_W immediate extender with 2-entry skid buffer
// Optional upper-placement mode (in_mode 2'b10) enabled by defining EXTEND_UPPER_EN.
module imm_extend_pipe #(
  parameter int IN_W  = 20,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_illegal
);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_in_ready;
  logic [OUT_W-1:0] r_head_data;
  logic             r_head_ill;
  logic [OUT_W-1:0] r_tail_data;
  logic             r_tail_ill;

  logic [OUT_W-1:0] w_sign;
  logic [OUT_W-1:0] w_zero;
`ifdef EXTEND_UPPER_EN
  logic [OUT_W-1:0] w_upper;
`endif
  logic [OUT_W-1:0] w_ext_data;
  logic             w_ext_ill;
  logic             w_accept;
  logic             w_drain;
  logic             w_load_head;
  logic             w_load_tail;
  logic             w_shift;

  // Equal widths bypass the replicate so no zero-width concatenation is built.
  generate
    if (OUT_W < IN_W) begin : g_bad_width
      $error("imm_extend_pipe: OUT_W must be >= IN_W");
    end else if (OUT_W == IN_W) begin : g_same_width
      assign w_sign  = in_data;
      assign w_zero  = in_data;
`ifdef EXTEND_UPPER_EN
      assign w_upper = in_data;
`endif
    end else begin : g_wide
      assign w_sign  = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};
      assign w_zero  = {{(OUT_W-IN_W){1'b0}}, in_data};
`ifdef EXTEND_UPPER_EN
      assign w_upper = {in_data, {(OUT_W-IN_W){1'b0}}};
`endif
    end
  endgenerate

  // Reserved modes still carry the sign-extended value, flagged illegal.
  always_comb begin
    w_ext_data = w_sign;
    w_ext_ill  = 1'b0;
    case (in_mode)
      2'b00: w_ext_data = w_sign;
      2'b01: w_ext_data = w_zero;
`ifdef EXTEND_UPPER_EN
      2'b10: w_ext_data = w_upper;
`else
      2'b10: w_ext_ill  = 1'b1;
`endif
      default: w_ext_ill = 1'b1;
    endcase
  end

  assign w_accept    = in_valid & r_in_ready;
  assign out_valid   = (r_state != ST_EMPTY);
  assign w_drain     = out_valid & out_ready;
  assign in_ready    = r_in_ready;
  assign out_data    = r_head_data;
  assign out_illegal = r_head_ill;

  always_comb begin
    w_next      = r_state;
    w_load_head = 1'b0;
    w_load_tail = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_next      = ST_ONE;
          w_load_head = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && w_drain) begin
          w_load_head = 1'b1;
        end else if (w_accept) begin
          w_next      = ST_TWO;
          w_load_tail = 1'b1;
        end else if (w_drain) begin
          w_next      = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_drain) begin
          w_next  = ST_ONE;
          w_shift = 1'b1;
        end
      end
      default: w_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b0;
      r_head_data <= '0;
      r_head_ill  <= 1'b0;
      r_tail_data <= '0;
      r_tail_ill  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != ST_TWO);
      if (w_load_head) begin
        r_head_data <= w_ext_data;
        r_head_ill  <= w_ext_ill;
      end else if (w_shift) begin
        r_head_data <= r_tail_data;
        r_head_ill  <= r_tail_ill;
      end
      if (w_load_tail) begin
        r_tail_data <= w_ext_data;
        r_tail_ill  <= w_ext_ill;
      end
    end
  end

endmodule
